// File: rtl/mux21_arbiter_if.sv
// Handshake bundle between two packet requesters, the arbiter and the
// downstream output stage. master = requester/sink side, slave = arbiter.
interface mux21_arbiter_if #(
    parameter int N = 8
);
    logic         req0_valid;
    logic [N-1:0] req0_data;
    logic         req0_last;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_data;
    logic         req1_last;
    logic         req1_ready;
    logic         sel;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_src;
    logic         out_last;
    logic         out_ready;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output out_ready,
        input  req0_ready, req1_ready, sel,
        input  out_valid, out_data, out_src, out_last
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  out_ready,
        output req0_ready, req1_ready, sel,
        output out_valid, out_data, out_src, out_last
    );
endinterface

// File: rtl/mux21_arbiter.sv
// Two-requester round-robin packet arbiter feeding one registered output
// beat stage. A grant is held from the first beat until the last beat of
// the packet is accepted; the priority pointer flips after every packet.
module mux21_arbiter #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux21_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t       state;
    logic         ptr;        // 0: prefer requester 0, 1: prefer requester 1
    logic         sel_q;
    logic         out_valid_q;
    logic [N-1:0] out_data_q;
    logic         out_src_q;
    logic         out_last_q;

    logic         load;
    logic         ready0;
    logic         ready1;
    logic         acc0;
    logic         acc1;

    // The output register can take a new beat when empty or draining now.
    assign load   = !out_valid_q || bus.out_ready;
    // Readies come only from the grant and the output stage, never from valid.
    assign ready0 = (state == GRANT0) && load;
    assign ready1 = (state == GRANT1) && load;
    assign acc0   = bus.req0_valid && ready0;
    assign acc1   = bus.req1_valid && ready1;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.sel        = sel_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_last   = out_last_q;

    // Grant FSM: arbitration in IDLE, hold until last beat, handover without bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0_valid && (!bus.req1_valid || !ptr)) begin
                        state <= GRANT0;
                        sel_q <= 1'b0;
                    end else if (bus.req1_valid) begin
                        state <= GRANT1;
                        sel_q <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (acc0 && bus.req0_last) begin
                        ptr <= 1'b1;
                        if (bus.req1_valid) begin
                            state <= GRANT1;
                            sel_q <= 1'b1;
                        end else if (!bus.req0_valid) begin
                            state <= IDLE;
                        end
                    end
                end
                GRANT1: begin
                    if (acc1 && bus.req1_last) begin
                        ptr <= 1'b0;
                        if (bus.req0_valid) begin
                            state <= GRANT0;
                            sel_q <= 1'b0;
                        end else if (!bus.req1_valid) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output beat register: load on accept, otherwise drop valid once drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (acc0) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.req0_data;
            out_src_q   <= 1'b0;
            out_last_q  <= bus.req0_last;
        end else if (acc1) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.req1_data;
            out_src_q   <= 1'b1;
            out_last_q  <= bus.req1_last;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux21_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_mux21_arbiter;
    localparam int N = 8;

    logic clk;
    logic rst;
    mux21_arbiter_if #(.N(N)) bus ();

    mux21_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, who is preferred, what the output holds.
    int         m_own  = -1;
    int         m_pref = 0;
    int         m_acc;
    bit         m_ov   = 0;
    bit         m_src  = 0;
    bit         m_last = 0;
    bit         m_sel  = 0;
    logic [7:0] m_data = 8'h00;
    bit         mv [2];
    bit         ml [2];
    logic [7:0] md [2];
    bit         m_ld;

    always @(posedge clk) begin
        mv[0] = bus.req0_valid; mv[1] = bus.req1_valid;
        ml[0] = bus.req0_last;  ml[1] = bus.req1_last;
        md[0] = bus.req0_data;  md[1] = bus.req1_data;
        if (rst) begin
            m_own = -1; m_pref = 0; m_ov = 0; m_src = 0; m_last = 0; m_sel = 0; m_data = 8'h00;
        end else begin
            m_ld  = !m_ov || bus.out_ready;
            m_acc = (m_own >= 0 && m_ld && mv[m_own]) ? m_own : -1;
            if (m_acc >= 0) begin
                m_ov = 1; m_src = m_acc[0]; m_last = ml[m_acc]; m_data = md[m_acc];
            end else if (m_ov && bus.out_ready) begin
                m_ov = 0;
            end
            if (m_own < 0) begin
                if (mv[0] && mv[1]) m_own = m_pref;
                else if (mv[0])     m_own = 0;
                else if (mv[1])     m_own = 1;
            end else if (m_acc >= 0 && ml[m_acc]) begin
                m_pref = 1 - m_acc;
                if (mv[1 - m_acc])  m_own = 1 - m_acc;
                else if (!mv[m_acc]) m_own = -1;
            end
            if (m_own >= 0) m_sel = m_own[0];
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("m_ready0", bus.req0_ready, (m_own == 0) && (!m_ov || bus.out_ready));
        chk("m_ready1", bus.req1_ready, (m_own == 1) && (!m_ov || bus.out_ready));
        chk("m_sel", bus.sel, m_sel);
        chk("m_out_valid", bus.out_valid, m_ov);
        chk("m_out_data", bus.out_data, m_data);
        chk("m_out_src", bus.out_src, m_src);
        chk("m_out_last", bus.out_last, m_last);
    end

    // Requester drivers: each holds its head beat until it is accepted.
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [8:0] olog [$];   // {src, data} of each beat leaving the output stage
    int  gap = 0;
    bit  rand_ready = 0;
    bit  f0, f1;

    task automatic cycle();
        @(negedge clk);
        f0 = bus.req0_valid && bus.req0_ready;
        f1 = bus.req1_valid && bus.req1_ready;
        if (bus.out_valid && bus.out_ready) olog.push_back({bus.out_src, bus.out_data});
        @(posedge clk);
        #1;
        if (f0 && q0.size() > 0) begin void'(q0.pop_front()); bus.req0_valid = 1'b0; end
        if (f1 && q1.size() > 0) begin void'(q1.pop_front()); bus.req1_valid = 1'b0; end
        if (!bus.req0_valid && q0.size() > 0 && $urandom_range(99) >= gap) begin
            bus.req0_valid = 1'b1; {bus.req0_last, bus.req0_data} = q0[0];
        end
        if (!bus.req1_valid && q1.size() > 0 && $urandom_range(99) >= gap) begin
            bus.req1_valid = 1'b1; {bus.req1_last, bus.req1_data} = q1[0];
        end
        if (rand_ready) bus.out_ready = ($urandom_range(99) < 70);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete(); q1.delete();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    logic [8:0] exp2 [4];
    logic [8:0] exp5 [3];
    logic [8:0] pk;
    int         len;

    initial begin
        rst = 1'b1;
        bus.req0_valid = 0; bus.req0_data = 0; bus.req0_last = 0;
        bus.req1_valid = 0; bus.req1_data = 0; bus.req1_last = 0;
        bus.out_ready = 1'b1;

        // Reset with both requesters already valid.
        q0.push_back({1'b1, 8'hA1});
        q1.push_back({1'b1, 8'hB2});
        cycle(); cycle();
        chk("t1_reset_valid", bus.out_valid, 0);
        chk("t1_reset_sel", bus.sel, 0);
        rst = 1'b0;
        cycle(); #2;
        chk("t1_c1_ready0", bus.req0_ready, 1);
        chk("t1_c1_ready1", bus.req1_ready, 0);
        cycle(); #2;
        chk("t1_c2_data", bus.out_data, 8'hA1);
        chk("t1_c2_src", bus.out_src, 0);
        chk("t1_c2_ready1", bus.req1_ready, 1);
        chk("t1_c2_sel", bus.sel, 1);
        cycle(); #2;
        chk("t1_c3_data", bus.out_data, 8'hB2);
        chk("t1_c3_src", bus.out_src, 1);

        // Packet hold: a 3-beat packet is not interleaved.
        do_reset();
        q0.push_back({1'b0, 8'h10}); q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h12});
        q1.push_back({1'b1, 8'h20});
        olog.delete();
        for (int i = 0; i < 20 && olog.size() < 4; i++) begin
            cycle(); #2;
            if (q0.size() > 0) chk("t2_ready1_hold", bus.req1_ready, 0);
        end
        exp2 = '{9'h010, 9'h011, 9'h012, 9'h120};
        chk("t2_count", olog.size(), 4);
        for (int i = 0; i < 4; i++) if (i < olog.size()) chk("t2_order", olog[i], exp2[i]);

        // Backpressure: output held stable, no accepts, then back-to-back reload.
        do_reset();
        q0.push_back({1'b1, 8'h55}); q0.push_back({1'b1, 8'h56});
        begin
            bit found = 0;
            for (int i = 0; i < 10 && !found; i++) begin
                cycle(); #2;
                found = bus.out_valid && (bus.out_data == 8'h55);
            end
            chk("t3_loaded", found, 1);
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(); #2;
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_hold_data", bus.out_data, 8'h55);
            chk("t3_hold_ready0", bus.req0_ready, 0);
        end
        bus.out_ready = 1'b1;
        cycle(); #2;
        chk("t3_reload_data", bus.out_data, 8'h56);
        chk("t3_reload_valid", bus.out_valid, 1);

        // Fairness: single-beat packets alternate sources.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            q0.push_back({1'b1, 8'(i)});
            q1.push_back({1'b1, 8'(8'h80 + i)});
        end
        olog.delete();
        for (int i = 0; i < 60 && olog.size() < 16; i++) cycle();
        chk("t4_count", olog.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < olog.size())
                chk("t4_beat", olog[i], (i % 2 == 0) ? {1'b0, 8'(i / 2 + 1)} : {1'b1, 8'(8'h80 + i / 2 + 1)});

        // Mid-packet gap keeps the grant.
        do_reset();
        olog.delete();
        q1.push_back({1'b0, 8'h30});
        for (int i = 0; i < 10 && q1.size() > 0; i++) cycle();
        q0.push_back({1'b1, 8'h40});
        for (int i = 0; i < 3; i++) begin
            cycle(); #2;
            chk("t5_gap_sel", bus.sel, 1);
            chk("t5_gap_ready0", bus.req0_ready, 0);
        end
        q1.push_back({1'b1, 8'h31});
        for (int i = 0; i < 20 && olog.size() < 3; i++) cycle();
        exp5 = '{9'h130, 9'h131, 9'h040};
        chk("t5_count", olog.size(), 3);
        for (int i = 0; i < 3; i++) if (i < olog.size()) chk("t5_order", olog[i], exp5[i]);

        // Reset during the gap drops everything.
        do_reset();
        q1.push_back({1'b0, 8'h30});
        for (int i = 0; i < 10 && q1.size() > 0; i++) cycle();
        cycle();
        do_reset();
        #2;
        chk("t5_rst_valid", bus.out_valid, 0);
        chk("t5_rst_ready0", bus.req0_ready, 0);
        chk("t5_rst_ready1", bus.req1_ready, 0);
        chk("t5_rst_sel", bus.sel, 0);

        // Randomized traffic with gaps and backpressure.
        do_reset();
        gap = 30;
        rand_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < 2; s++) begin
                if ((s == 0 ? q0.size() : q1.size()) < 3 && $urandom_range(3) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        pk = {(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)};
                        if (s == 0) q0.push_back(pk); else q1.push_back(pk);
                    end
                end
            end
            cycle();
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        olog.delete();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux21_arbiter.md
Name: mux21_arbiter

Overview:
- Round-robin arbiter that shares one N-bit datapath between two requesters.
- Drives the select of the downstream 2:1 bus multiplexer.
- Each requester sends packets of one or more beats over a valid/ready handshake. A grant is held until the packet's last beat.
- Output is one registered beat stage toward the shared ALU/output bus.

Parameters:
N, 8, data bus width of each requester and of the output

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 beat available
req0_data  input  N  requester 0 beat data
req0_last  input  1  requester 0 beat is final beat of packet
req0_ready  output  1  requester 0 beat accepted this cycle when high with req0_valid
req1_valid  input  1  requester 1 beat available
req1_data  input  N  requester 1 beat data
req1_last  input  1  requester 1 beat is final beat of packet
req1_ready  output  1  requester 1 beat accepted this cycle when high with req1_valid
sel  output  1  current mux select (0 = requester 0, 1 = requester 1); equals granted source
out_valid  output  1  output register holds a beat
out_data  output  N  registered beat data
out_src  output  1  source id of the registered beat
out_last  output  1  registered beat is final beat of packet
out_ready  input  1  downstream accepts beat when high with out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE; priority pointer prefers requester 0.
  - out_valid=0, out_data=0, out_src=0, out_last=0.
  - sel=0, req0_ready=0, req1_ready=0.
- States:
  - IDLE: no grant. Both readies are 0.
  - GRANT0, GRANT1: grant held by requester 0 or 1.
- Load enable: load = !out_valid || out_ready.
- Ready:
  - reqX_ready = (state==GRANTX) && load.
  - The non-granted ready is always 0. Readies never depend on reqX_valid.
- Accept:
  - A beat is accepted when reqX_valid && reqX_ready.
  - Same edge: out_data<=reqX_data, out_src<=X, out_last<=reqX_last, out_valid<=1.
- Drain: if out_valid && out_ready and no accept occurs, out_valid<=0. Data fields hold their last value.
- Output stability: while out_valid && !out_ready, all out_* fields are held stable.
- IDLE arbitration:
  - Only one reqX_valid → GRANTX next cycle.
  - Both valid → grant the pointer-preferred requester.
  - Neither → stay in IDLE.
  - Arbitration latency is 1 cycle from valid to ready.
- Grant hold: GRANTX stays until requester X's last beat is accepted. Valid gaps mid-packet do not release the grant.
- On accept of a last beat from X:
  - Pointer moves to prefer the other requester.
  - Next state is GRANT(other) if req(other)_valid this cycle.
  - Otherwise GRANTX if reqX_valid, otherwise IDLE.
  - No bubble cycle on handover.
- sel:
  - sel = 1 in GRANT1; sel = 0 in GRANT0.
  - In IDLE, sel holds its previous value. It is 0 after reset.
- Mid-operation reset: rst overrides everything on the same edge. In-flight packet state is discarded and the output beat is dropped.
- Throughput:
  - Single-beat packets from both sides alternate with 1 beat/cycle sustained while out_ready=1.
  - Peak throughput is 1 beat/cycle.
- Prohibited upstream behaviour: an upstream beat that deasserts valid or changes data while valid && !ready is a protocol violation, not handled.

Test Plan:
1. Reset with both requests high, N=8:
   - Stimulus: rst=1 for 2 cycles, then rst=0; req0 data 0xA1 last=1, req1 data 0xB2 last=1, both valid, out_ready=1.
   - Response: cycle1 GRANT0; req0_ready=1 in cycle1; out_data=0xA1 src=0 in cycle2. Then GRANT1 with no bubble; out_data=0xB2 src=1 in cycle3.
2. Packet hold:
   - Stimulus: req0 sends 3-beat packet 0x10,0x11,0x12 (last on 0x12) while req1 is continuously valid with 0x20 last=1.
   - Response: output order is 0x10,0x11,0x12,0x20. req1_ready stays 0 until after 0x12 is accepted.
3. Backpressure:
   - Stimulus: out_ready=0 for 4 cycles with a beat 0x55 held in the output.
   - Response: out_valid=1, out_data=0x55 stable, req0_ready=0 throughout. Release out_ready=1 → next beat loads the same edge 0x55 drains.
4. Fairness:
   - Stimulus: both requesters present continuous single-beat packets (req0 0x01.., req1 0x81..) for 8 beats.
   - Response: out_src alternates 0,1,0,1,...; sel matches the granted side.
5. Mid-packet gap and reset:
   - Stimulus: req1 packet 0x30 (last=0), then valid low 3 cycles, then 0x31 last=1.
   - Response: the grant stays GRANT1 through the gap and both beats are output.
   - Stimulus (repeat): assert rst during the gap.
   - Response: next cycle out_valid=0, state IDLE, both readies 0, sel=0.
